// File: rtl/ifu_fetch.sv
// Non-speculative instruction fetch: one AXI4-Lite-style read per PC, handed to decode via valid/ready.
// Optional performance counters are compiled in when IFU_PERF_CNT_EN is defined.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        pc_write_enable,
    input  logic        idu_ready,
    output logic        ifu_send_valid,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        SEND,
        WAIT_PC
    } state_t;

    state_t state;

    // The response code has no effect on fetch; it is deliberately left unused.
    logic unused_rresp;
    assign unused_rresp = ^rresp;

    assign araddr = pc;

    // Handshake flags are registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            insn           <= NOP_INSN;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            ifu_send_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= ADDR;
                    arvalid <= 1'b1;
                end
                ADDR: begin
                    if (arready) begin
                        state   <= DATA;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        state          <= SEND;
                        insn           <= rdata;
                        rready         <= 1'b0;
                        ifu_send_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (idu_ready) begin
                        state          <= WAIT_PC;
                        ifu_send_valid <= 1'b0;
                    end
                end
                WAIT_PC: begin
                    if (pc_write_enable) begin
                        state   <= ADDR;
                        pc      <= {pc_next[31:2], 2'b00};
                        arvalid <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    arvalid        <= 1'b0;
                    rready         <= 1'b0;
                    ifu_send_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Stall cycles are those where the bus handshake of the current phase does not complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (ifu_send_valid && idu_ready)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state == ADDR && !arready) || (state == DATA && !rvalid))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
